// File: rtl/alu_operand_stage_if.sv
// ID-to-EX operand bundle: instruction fields, forwarding sources and the EX-side valid/ready result.
// The master drives the ID and forwarding fields and out_ready. The slave (the operand stage) drives in_ready and the out_* fields.
interface alu_operand_stage_if #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_rs1_data;
    logic [XLEN-1:0] in_rs2_data;
    logic [RA_W-1:0] in_rs1_addr;
    logic [RA_W-1:0] in_rs2_addr;
    logic [XLEN-1:0] in_imm;
    logic [XLEN-1:0] in_pc;
    logic [1:0]      in_a_sel;
    logic            in_alusrc;
    logic            exmem_regwrite;
    logic [RA_W-1:0] exmem_rd;
    logic [XLEN-1:0] exmem_data;
    logic            memwb_regwrite;
    logic [RA_W-1:0] memwb_rd;
    logic [XLEN-1:0] memwb_data;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_op_a;
    logic [XLEN-1:0] out_op_b;
    logic [XLEN-1:0] out_store_data;
    logic [1:0]      out_fwd_a;
    logic [1:0]      out_fwd_b;

    modport master (
        output in_valid, in_rs1_data, in_rs2_data, in_rs1_addr, in_rs2_addr,
               in_imm, in_pc, in_a_sel, in_alusrc,
               exmem_regwrite, exmem_rd, exmem_data,
               memwb_regwrite, memwb_rd, memwb_data, out_ready,
        input  in_ready, out_valid, out_op_a, out_op_b, out_store_data,
               out_fwd_a, out_fwd_b
    );

    modport slave (
        input  in_valid, in_rs1_data, in_rs2_data, in_rs1_addr, in_rs2_addr,
               in_imm, in_pc, in_a_sel, in_alusrc,
               exmem_regwrite, exmem_rd, exmem_data,
               memwb_regwrite, memwb_rd, memwb_data, out_ready,
        output in_ready, out_valid, out_op_a, out_op_b, out_store_data,
               out_fwd_a, out_fwd_b
    );
endinterface

// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: forwarding followed by operand A/B select. Accepted instructions reach the output after 1 cycle.
// A one-entry skid register absorbs EX stalls. in_ready is low only while the skid register is occupied.
module alu_operand_stage #(
    parameter int XLEN   = 32,
    parameter int RA_W   = 5,
    parameter bit FWD_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    alu_operand_stage_if.slave bus
);

    typedef struct packed {
        logic [XLEN-1:0] op_a;
        logic [XLEN-1:0] op_b;
        logic [XLEN-1:0] store_data;
        logic [1:0]      fwd_a;
        logic [1:0]      fwd_b;
    } entry_t;

    localparam logic [1:0] FWD_NONE  = 2'd0;
    localparam logic [1:0] FWD_MEMWB = 2'd1;
    localparam logic [1:0] FWD_EXMEM = 2'd2;

    logic [XLEN-1:0] rs1_fwd, rs2_fwd;
    logic [1:0]      rs1_src, rs2_src;
    entry_t          new_entry;
    entry_t          main_q, main_d, skid_q, skid_d;
    logic            out_valid_q, out_valid_d;
    logic            skid_valid_q, skid_valid_d;
    logic            accept;

    generate
        if (FWD_EN) begin : g_fwd
            logic ex_hit1, wb_hit1, ex_hit2, wb_hit2;

            // x0 is hard-wired to zero, so a pending write to it is never forwarded
            assign ex_hit1 = bus.exmem_regwrite && (bus.exmem_rd != '0) && (bus.exmem_rd == bus.in_rs1_addr);
            assign wb_hit1 = bus.memwb_regwrite && (bus.memwb_rd != '0) && (bus.memwb_rd == bus.in_rs1_addr);
            assign ex_hit2 = bus.exmem_regwrite && (bus.exmem_rd != '0) && (bus.exmem_rd == bus.in_rs2_addr);
            assign wb_hit2 = bus.memwb_regwrite && (bus.memwb_rd != '0) && (bus.memwb_rd == bus.in_rs2_addr);

            always_comb begin
                rs1_fwd = bus.in_rs1_data;
                rs1_src = FWD_NONE;
                rs2_fwd = bus.in_rs2_data;
                rs2_src = FWD_NONE;
                if (ex_hit1) begin
                    rs1_fwd = bus.exmem_data;
                    rs1_src = FWD_EXMEM;
                end else if (wb_hit1) begin
                    rs1_fwd = bus.memwb_data;
                    rs1_src = FWD_MEMWB;
                end
                if (ex_hit2) begin
                    rs2_fwd = bus.exmem_data;
                    rs2_src = FWD_EXMEM;
                end else if (wb_hit2) begin
                    rs2_fwd = bus.memwb_data;
                    rs2_src = FWD_MEMWB;
                end
            end
        end else begin : g_nofwd
            assign rs1_fwd = bus.in_rs1_data;
            assign rs2_fwd = bus.in_rs2_data;
            assign rs1_src = FWD_NONE;
            assign rs2_src = FWD_NONE;
        end
    endgenerate

    always_comb begin
        new_entry            = '0;
        new_entry.store_data = rs2_fwd;
        new_entry.fwd_b      = rs2_src;
        new_entry.op_b       = bus.in_alusrc ? bus.in_imm : rs2_fwd;
        case (bus.in_a_sel)
            2'd0: begin
                new_entry.op_a  = rs1_fwd;
                new_entry.fwd_a = rs1_src;
            end
            2'd1:    new_entry.op_a = bus.in_pc;
            default: new_entry.op_a = '0;
        endcase
    end

    assign bus.in_ready = !skid_valid_q;
    assign accept       = bus.in_valid && !skid_valid_q;

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || bus.out_ready) begin
            // A full skid register holds in_ready low, so draining it and accepting never coincide
            if (skid_valid_q) begin
                main_d       = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d      = new_entry;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = new_entry;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q       <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign bus.out_valid      = out_valid_q;
    assign bus.out_op_a       = main_q.op_a;
    assign bus.out_op_b       = main_q.op_b;
    assign bus.out_store_data = main_q.store_data;
    assign bus.out_fwd_a      = main_q.fwd_a;
    assign bus.out_fwd_b      = main_q.fwd_b;

endmodule
